// File: rtl/vpu_line_sched.sv
// vpu_line_sched: per-scanline DMA setup sequencer for the VPU register port.
// On each qualifying line tick it issues a fixed six-write sequence:
//   external address, step, cache pointer, and finally length, which starts the transfer.
// CPU accesses to the VPU port pass through while idle and are stalled otherwise.
module vpu_line_sched #(
    parameter logic [15:0] CACHE_BASE = 16'h0000,
    parameter logic [7:0]  DMA_STEP   = 8'h01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       line_tick,
    input  logic       frame_start,
    input  logic       s_cs,
    input  logic       s_rw,
    input  logic [2:0] s_ad,
    input  logic [7:0] s_di,
    output logic [7:0] s_do,
    input  logic       c_cs,
    input  logic       c_rw,
    input  logic [4:0] c_ad,
    input  logic [7:0] c_di,
    output logic       c_wait,
    output logic       v_cs,
    output logic       v_rw,
    output logic [4:0] v_ad,
    output logic [7:0] v_di
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_W_AH = 3'd1,
        S_W_AL = 3'd2,
        S_W_ST = 3'd3,
        S_W_CH = 3'd4,
        S_W_CL = 3'd5,
        S_W_LN = 3'd6
    } state_t;

    state_t      state_q, state_d;

    // Programmed configuration
    logic [7:0]  base_hi_q, base_hi_d;
    logic [7:0]  base_lo_q, base_lo_d;
    logic [7:0]  stride_q, stride_d;
    logic [7:0]  length_q, length_d;
    logic [7:0]  first_q, first_d;
    logic [7:0]  count_q, count_d;
    logic        en_q, en_d;
    logic        ovr_q, ovr_d;
    logic [7:0]  s_do_q, s_do_d;

    // Per-frame working state
    logic [15:0] cur_addr_q, cur_addr_d;
    logic [8:0]  line_cnt_q, line_cnt_d;
    logic [7:0]  remain_q, remain_d;
    logic        fs_pend_q, fs_pend_d;

    logic        busy_s;
    logic        start_ok_s;
    logic        s_wr_s;
    logic        s_rd_s;
    logic [7:0]  rd_data_s;
    logic [4:0]  seq_ad_s;
    logic [7:0]  seq_di_s;

    assign busy_s     = (state_q != S_IDLE);
    assign s_wr_s     = s_cs & ~s_rw;
    assign s_rd_s     = s_cs & s_rw;
    assign start_ok_s = (line_cnt_q >= {1'b0, first_q}) && (remain_q != 8'h00);

    // Next-state and per-state VPU write address/data for the setup sequence
    always_comb begin
        state_d  = state_q;
        seq_ad_s = 5'h00;
        seq_di_s = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (!frame_start && line_tick && en_q && start_ok_s) begin
                    state_d = S_W_AH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_W_AH: begin
                state_d  = S_W_AL;
                seq_ad_s = 5'h0C;
                seq_di_s = cur_addr_q[15:8];
            end
            S_W_AL: begin
                state_d  = S_W_ST;
                seq_ad_s = 5'h0D;
                seq_di_s = cur_addr_q[7:0];
            end
            S_W_ST: begin
                state_d  = S_W_CH;
                seq_ad_s = 5'h0E;
                seq_di_s = DMA_STEP;
            end
            S_W_CH: begin
                state_d  = S_W_CL;
                seq_ad_s = 5'h00;
                seq_di_s = CACHE_BASE[15:8];
            end
            S_W_CL: begin
                state_d  = S_W_LN;
                seq_ad_s = 5'h01;
                seq_di_s = CACHE_BASE[7:0];
            end
            S_W_LN: begin
                state_d  = S_IDLE;
                seq_ad_s = 5'h0F;
                seq_di_s = length_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Frame/line bookkeeping: frame restart, line counting, stride advance
    always_comb begin
        cur_addr_d = cur_addr_q;
        line_cnt_d = line_cnt_q;
        remain_d   = remain_q;
        fs_pend_d  = fs_pend_q;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    // frame_start wins over a coincident tick
                    cur_addr_d = {base_hi_q, base_lo_q};
                    line_cnt_d = 9'd0;
                    remain_d   = count_q;
                    fs_pend_d  = 1'b0;
                end else if (line_tick && en_q) begin
                    if (line_cnt_q != 9'h1FF) begin
                        line_cnt_d = line_cnt_q + 9'd1;
                    end else begin
                        line_cnt_d = line_cnt_q;
                    end
                end else begin
                    line_cnt_d = line_cnt_q;
                end
            end
            S_W_LN: begin
                cur_addr_d = cur_addr_q + {8'h00, stride_q};
                remain_d   = remain_q - 8'd1;
                if (fs_pend_q || frame_start) begin
                    // deferred frame restart overrides the stride update
                    cur_addr_d = {base_hi_q, base_lo_q};
                    line_cnt_d = 9'd0;
                    remain_d   = count_q;
                    fs_pend_d  = 1'b0;
                end else begin
                    fs_pend_d  = fs_pend_q;
                end
            end
            default: begin
                if (frame_start) begin
                    fs_pend_d = 1'b1;
                end else begin
                    fs_pend_d = fs_pend_q;
                end
            end
        endcase
    end

    // Scheduler register file: writes, read mux, overrun flag
    always_comb begin
        base_hi_d = base_hi_q;
        base_lo_d = base_lo_q;
        stride_d  = stride_q;
        length_d  = length_q;
        first_d   = first_q;
        count_d   = count_q;
        en_d      = en_q;
        ovr_d     = ovr_q;
        rd_data_s = 8'h00;
        if (s_wr_s) begin
            case (s_ad)
                3'd0:    base_hi_d = s_di;
                3'd1:    base_lo_d = s_di;
                3'd2:    stride_d  = s_di;
                3'd3:    length_d  = s_di;
                3'd4:    first_d   = s_di;
                3'd5:    count_d   = s_di;
                3'd6:    en_d      = s_di[7];
                default: en_d      = en_q;
            endcase
        end else begin
            en_d = en_q;
        end
        case (s_ad)
            3'd0:    rd_data_s = base_hi_q;
            3'd1:    rd_data_s = base_lo_q;
            3'd2:    rd_data_s = stride_q;
            3'd3:    rd_data_s = length_q;
            3'd4:    rd_data_s = first_q;
            3'd5:    rd_data_s = count_q;
            3'd6:    rd_data_s = {en_q, 5'b00000, ovr_q, busy_s};
            3'd7:    rd_data_s = cur_addr_q[15:8];
            default: rd_data_s = 8'h00;
        endcase
        if (s_rd_s && (s_ad == 3'd6)) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
        // a fresh overrun is never lost to a coincident clear
        if (busy_s && line_tick) begin
            ovr_d = 1'b1;
        end else begin
            ovr_d = ovr_d;
        end
        if (s_rd_s) begin
            s_do_d = rd_data_s;
        end else begin
            s_do_d = s_do_q;
        end
    end

    // State and register update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            base_hi_q  <= 8'h00;
            base_lo_q  <= 8'h00;
            stride_q   <= 8'h00;
            length_q   <= 8'h00;
            first_q    <= 8'h00;
            count_q    <= 8'h00;
            en_q       <= 1'b0;
            ovr_q      <= 1'b0;
            s_do_q     <= 8'h00;
            cur_addr_q <= 16'h0000;
            line_cnt_q <= 9'd0;
            remain_q   <= 8'h00;
            fs_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_hi_q  <= base_hi_d;
            base_lo_q  <= base_lo_d;
            stride_q   <= stride_d;
            length_q   <= length_d;
            first_q    <= first_d;
            count_q    <= count_d;
            en_q       <= en_d;
            ovr_q      <= ovr_d;
            s_do_q     <= s_do_d;
            cur_addr_q <= cur_addr_d;
            line_cnt_q <= line_cnt_d;
            remain_q   <= remain_d;
            fs_pend_q  <= fs_pend_d;
        end
    end

    // VPU port mux: CPU passthrough when idle, sequencer otherwise
    always_comb begin
        if (busy_s) begin
            v_cs   = 1'b1;
            v_rw   = 1'b0;
            v_ad   = seq_ad_s;
            v_di   = seq_di_s;
            c_wait = c_cs;
        end else begin
            v_cs   = c_cs;
            v_rw   = c_rw;
            v_ad   = c_ad;
            v_di   = c_di;
            c_wait = 1'b0;
        end
    end

    assign s_do = s_do_q;

endmodule

// File: tb/tb_vpu_line_sched.sv
// Directed bench for vpu_line_sched: logs every VPU-port write and checks
// sequences, overrun, CPU stalling, frame restart and async reset.
module tb_vpu_line_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       line_tick, frame_start;
    logic       s_cs, s_rw;
    logic [2:0] s_ad;
    logic [7:0] s_di, s_do;
    logic       c_cs, c_rw;
    logic [4:0] c_ad;
    logic [7:0] c_di;
    logic       c_wait, v_cs, v_rw;
    logic [4:0] v_ad;
    logic [7:0] v_di;

    int errors = 0;
    int checks = 0;
    logic [15:0] wlog [$];
    logic [7:0]  rd;

    vpu_line_sched #(.CACHE_BASE(16'h0000), .DMA_STEP(8'h01)) dut (
        .clk(clk), .rst_n(rst_n), .line_tick(line_tick), .frame_start(frame_start),
        .s_cs(s_cs), .s_rw(s_rw), .s_ad(s_ad), .s_di(s_di), .s_do(s_do),
        .c_cs(c_cs), .c_rw(c_rw), .c_ad(c_ad), .c_di(c_di), .c_wait(c_wait),
        .v_cs(v_cs), .v_rw(v_rw), .v_ad(v_ad), .v_di(v_di)
    );

    always #5 clk = ~clk;

    // record every write presented on the VPU port
    always @(posedge clk) begin
        if (rst_n && v_cs && !v_rw) wlog.push_back({3'b000, v_ad, v_di});
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) step();
    endtask

    task automatic tick();
        line_tick = 1'b1;
        step();
        line_tick = 1'b0;
    endtask

    task automatic fstart();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic swr(input logic [2:0] a, input logic [7:0] d);
        s_cs = 1'b1; s_rw = 1'b0; s_ad = a; s_di = d;
        step();
        s_cs = 1'b0;
    endtask

    task automatic srd(input logic [2:0] a, output logic [7:0] d);
        s_cs = 1'b1; s_rw = 1'b1; s_ad = a;
        step();
        s_cs = 1'b0;
        d = s_do;
    endtask

    initial begin
        rst_n = 1'b0; line_tick = 1'b0; frame_start = 1'b0;
        s_cs = 1'b0; s_rw = 1'b0; s_ad = 3'd0; s_di = 8'h00;
        c_cs = 1'b0; c_rw = 1'b0; c_ad = 5'h00; c_di = 8'h00;
        #3;
        // reset state
        chk("rst_s_do", {8'h00, s_do}, 16'h0000);
        chk("rst_c_wait", {15'h0, c_wait}, 16'h0000);
        chk("rst_v_cs", {15'h0, v_cs}, 16'h0000);
        chk("rst_v_ad", {11'h0, v_ad}, 16'h0000);
        #10 rst_n = 1'b1;
        step();
        srd(3'd6, rd);
        chk("rst_ctrl", {8'h00, rd}, 16'h0000);

        // two-line frame, third tick exhausted
        swr(3'd0, 8'h12); swr(3'd1, 8'h34); swr(3'd2, 8'h28); swr(3'd3, 8'h28);
        swr(3'd4, 8'h00); swr(3'd5, 8'h02); swr(3'd6, 8'h80);
        srd(3'd0, rd);
        chk("rd_base_hi", {8'h00, rd}, 16'h0012);
        fstart();
        wlog.delete();
        tick();
        chk("t1_wah_ad", {11'h0, v_ad}, 16'h000C);
        chk("t1_wah_di", {8'h00, v_di}, 16'h0012);
        srd(3'd6, rd);
        chk("t1_busy", {8'h00, rd}, 16'h0081);
        wait_n(20);
        tick(); wait_n(20);
        tick(); wait_n(20);
        chk("t1_nwr", 16'(wlog.size()), 16'd12);
        chk("t1_w0", wlog[0], 16'h0C12);
        chk("t1_w1", wlog[1], 16'h0D34);
        chk("t1_w2", wlog[2], 16'h0E01);
        chk("t1_w3", wlog[3], 16'h0000);
        chk("t1_w4", wlog[4], 16'h0100);
        chk("t1_w5", wlog[5], 16'h0F28);
        chk("t1_w6", wlog[6], 16'h0C12);
        chk("t1_w7", wlog[7], 16'h0D5C);
        srd(3'd6, rd);
        chk("t1_idle_ctrl", {8'h00, rd}, 16'h0080);

        // first line = 3, one line: only the 4th tick fires
        swr(3'd4, 8'h03); swr(3'd5, 8'h01);
        fstart();
        wlog.delete();
        for (int i = 0; i < 3; i++) begin
            tick(); wait_n(10);
        end
        chk("t2_before", 16'(wlog.size()), 16'd0);
        tick(); wait_n(10);
        chk("t2_fourth", 16'(wlog.size()), 16'd6);
        chk("t2_addr", wlog[0], 16'h0C12);
        tick(); wait_n(10);
        tick(); wait_n(10);
        chk("t2_total", 16'(wlog.size()), 16'd6);

        // overrun: second tick 3 clk after the first
        swr(3'd4, 8'h00); swr(3'd5, 8'h05);
        fstart();
        wlog.delete();
        tick(); step(); step();
        tick();
        wait_n(10);
        chk("t3_nwr", 16'(wlog.size()), 16'd6);
        srd(3'd6, rd);
        chk("t3_ovr_set", {8'h00, rd}, 16'h0082);
        srd(3'd6, rd);
        chk("t3_ovr_clr", {8'h00, rd}, 16'h0080);

        // CPU write stalled during a sequence
        tick();          // cycle T+1
        step();          // cycle T+2
        c_cs = 1'b1; c_rw = 1'b0; c_ad = 5'h03; c_di = 8'h55;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_wait", {15'h0, c_wait}, 16'h0001);
            chk("t4_vad_seq", {15'h0, v_ad == 5'h03}, 16'h0000);
            step();
        end
        chk("t4_wait_rel", {15'h0, c_wait}, 16'h0000);
        chk("t4_vad", {11'h0, v_ad}, 16'h0003);
        chk("t4_vdi", {8'h00, v_di}, 16'h0055);
        step();
        c_cs = 1'b0; c_ad = 5'h00; c_di = 8'h00;
        wait_n(5);

        // frame_start mid-sequence, then stride wrap
        swr(3'd0, 8'hFF); swr(3'd1, 8'hF0); swr(3'd2, 8'h20);
        fstart();
        wlog.delete();
        tick(); step();
        fstart();
        wait_n(10);
        chk("t5_ah", wlog[0], 16'h0CFF);
        chk("t5_al", wlog[1], 16'h0DF0);
        srd(3'd7, rd);
        chk("t5_cur_base", {8'h00, rd}, 16'h00FF);
        tick(); wait_n(10);
        chk("t5_ah2", wlog[6], 16'h0CFF);
        chk("t5_al2", wlog[7], 16'h0DF0);
        srd(3'd7, rd);
        chk("t5_cur_wrap", {8'h00, rd}, 16'h0000);
        tick(); wait_n(10);
        chk("t5_ah3", wlog[12], 16'h0C00);
        chk("t5_al3", wlog[13], 16'h0D10);

        // async reset during W_CH
        tick();          // T+1
        wait_n(3);       // T+4 = W_CH
        c_cs = 1'b1; c_rw = 1'b1; c_ad = 5'h07; c_di = 8'hA5;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_vcs", {15'h0, v_cs}, 16'h0001);
        chk("t6_vrw", {15'h0, v_rw}, 16'h0001);
        chk("t6_vad", {11'h0, v_ad}, 16'h0007);
        chk("t6_vdi", {8'h00, v_di}, 16'h00A5);
        chk("t6_cwait", {15'h0, c_wait}, 16'h0000);
        c_cs = 1'b0; c_rw = 1'b0; c_ad = 5'h00; c_di = 8'h00;
        step();
        rst_n = 1'b1;
        step();
        srd(3'd6, rd);
        chk("t6_ctrl", {8'h00, rd}, 16'h0000);
        srd(3'd2, rd);
        chk("t6_stride", {8'h00, rd}, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vpu_line_sched.md
# vpu_line_sched

Per-scanline DMA scheduler for the video processing unit. On every line tick inside a programmed window it drives a fixed six-write sequence into the VPU register port to set up that line's DMA:

- external address
- step
- cache pointer
- length (this write starts the transfer)

After each sequence it advances the external address by a stride. It sits between the CPU bus and the VPU register port, passes CPU accesses through when idle and stalls them while a sequence is in progress.

## Interface
Parameters:
- CACHE_BASE, 16'h0000, cache pointer written to VPU $0/$1 each line
- DMA_STEP, 8'h01, value written to VPU $E each line

Ports:
- clk  in  1  system clock, same clock as the VPU register port
- rst_n  in  1  asynchronous active-low reset
- line_tick  in  1  one-cycle pulse at the start of each scanline
- frame_start  in  1  one-cycle pulse at the start of each frame
- s_cs  in  1  scheduler register select
- s_rw  in  1  1 = read, 0 = write
- s_ad  in  3  scheduler register address
- s_di  in  8  write data
- s_do  out  8  registered read data
- c_cs  in  1  CPU select for a VPU register
- c_rw  in  1  CPU read/write
- c_ad  in  5  CPU VPU register address
- c_di  in  8  CPU write data
- c_wait  out  1  CPU access stalled; the CPU holds its request
- v_cs  out  1  VPU register port select
- v_rw  out  1  VPU register port read/write
- v_ad  out  5  VPU register port address
- v_di  out  8  VPU register port write data

## Operation
Scheduler registers (s_ad):
- 0: base[15:8]
- 1: base[7:0]
- 2: stride (8-bit, zero-extended)
- 3: length
- 4: first line
- 5: line count
- 6: ctrl
  - bit7 EN (RW)
  - bit1 OVR (R; cleared by a read of reg 6)
  - bit0 BUSY (R)
- 7: reads cur_addr[15:8]
- All reads of registers 0-5 return the written value.
- Unused ctrl bits read 0.

Internal state:
- cur_addr[15:0]
- line_cnt[8:0]
- remain[7:0]

frame_start (applied in IDLE):
- cur_addr <= base
- line_cnt <= 0
- remain <= line count

line_tick in IDLE with EN=1:
- line_cnt increments, saturating at 511.
- If the pre-increment line_cnt >= first line and remain != 0, the FSM leaves IDLE and runs the write sequence.

States, each exactly one cycle, with v_cs=1 and v_rw=0 throughout:
- IDLE
- W_AH: v_ad=$0C, v_di=cur_addr[15:8]
- W_AL: v_ad=$0D, v_di=cur_addr[7:0]
- W_ST: v_ad=$0E, v_di=DMA_STEP
- W_CH: v_ad=$00, v_di=CACHE_BASE[15:8]
- W_CL: v_ad=$01, v_di=CACHE_BASE[7:0]
- W_LN: v_ad=$0F, v_di=length
- Sequence order: IDLE -> W_AH -> W_AL -> W_ST -> W_CH -> W_CL -> W_LN -> IDLE.
- In W_LN: cur_addr <= cur_addr + stride (mod 2^16) and remain <= remain - 1.

Port mux:
- In IDLE, v_cs/v_rw/v_ad/v_di = c_cs/c_rw/c_ad/c_di combinationally and c_wait=0.
- Otherwise the scheduler drives the port and c_wait = c_cs.

Boundary conditions:
- line_tick while not IDLE: tick ignored, line_cnt unchanged, OVR set.
- frame_start while not IDLE: latched pending and applied on the W_LN -> IDLE cycle, after the stride update, so the base wins.
- frame_start and line_tick in the same IDLE cycle: frame_start applied, tick ignored.
- EN cleared mid-sequence: the sequence completes; no new sequence starts.
- Scheduler register writes mid-sequence take effect immediately. length is sampled in W_LN.
- Stride 0: the same address is fetched every line.

## Timing
- Reset (async): all registers 0 except EN=0, and FSM=IDLE. s_do=0 and c_wait=0; v_* follows c_* (all 0 if c_* are 0).
- line_tick sampled at edge T: W_AH occupies cycle T+1 and W_LN cycle T+6. BUSY reads 1 for T+1..T+6, and the FSM is in IDLE from T+7.
- A CPU access that coincides with the tick cycle passes through in that cycle.
- A CPU access arriving during T+1..T+6 sees c_wait=1 and completes in the first IDLE cycle.
- s_do is updated on the edge after a s_cs&s_rw cycle.
- Minimum line period with no overrun: 7 clk.

## Test plan
- Reset, then base=$1234, stride=$28, length=$28, first=0, count=2, EN=1, frame_start, two line_ticks 20 clk apart -> two sequences; the $0C/$0D writes are $12/$34 then $12/$5C. A third tick writes nothing (remain=0).
- first=3, count=1, ticks 0..5 -> exactly one sequence, on the 4th tick.
- line_tick 3 clk after a previous tick -> second tick ignored, OVR=1; reading reg 6 returns OVR=1, and the next read returns OVR=0.
- CPU write c_ad=$03 asserted at T+2 of a sequence -> c_wait=1 through T+6; v_ad=$03 appears at T+7.
- base=$FFF0, stride=$20, frame_start mid-sequence -> the addresses written by this sequence are unaffected; cur_addr reads $FFF0 after W_LN. Separately, with no frame_start, the next address wraps to $0010.
- rst_n asserted during W_CH -> v_* immediately follows c_*, BUSY=0, EN=0.
